ahb_arbiter_nm: RTL and testbench
=================================

Name: ahb_arbiter_nm

Overview:
Parametrised AHB-Lite multi-master arbiter. It muxes NMASTER masters (CPU, DMA engines, debug) onto one AHB-Lite slave bus. Unlike the current two-master CPU/DMA switch, it tracks the address and data phases separately, switches only at transfer boundaries, stalls non-granted masters through HREADY, and offers fixed or round-robin priority with a bounded hold time. It sits between the masters and the AHB decoder/interconnect.

Parameters:
NMASTER, 2, number of masters (2..8); index 0 is the highest fixed priority.
ARB_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin starting at owner+1.
MAX_HOLD, 4, single transfers an owner may issue while others wait before it is preempted; 0 disables preemption.
PARK, 0, master granted out of reset.

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HADDRm  in  NMASTER*32  master addresses, master i at [32i+:32]
HBURSTm  in  NMASTER*3  master HBURST
HMASTLOCKm  in  NMASTER  master lock
HPROTm  in  NMASTER*4  master HPROT
HSIZEm  in  NMASTER*3  master HSIZE
HTRANSm  in  NMASTER*2  master HTRANS
HWDATAm  in  NMASTER*32  master write data
HWRITEm  in  NMASTER  master HWRITE
HRDATAm  out  NMASTER*32  read data per master
HREADYm  out  NMASTER  ready per master
HRESPm  out  NMASTER  response per master
HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE  out  32/3/1/4/3/2/32/1  slave-side bus
HRDATA  in  32  slave read data
HREADY  in  1  slave ready
HRESP  in  1  slave response
HMASTER  out  max(1,clog2(NMASTER))  current address-phase owner
HGRANT  out  NMASTER  one-hot copy of HMASTER

Behaviour:
- Single clock HCLK; HRESETn asynchronous active-low. On reset: aown=PARK, down=0, dvalid=0, holdcnt=0.
- Registers: aown (address-phase owner), down/dvalid (data-phase owner and valid), holdcnt.
- req[i] = HTRANSm[i][1] (NONSEQ or SEQ).
- Address mux: HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS and HWRITE come from aown. HWDATA comes from down. All are combinational.
- Ready routing for master i:
  - i==down && dvalid: HREADYm[i] = HREADY.
  - else i==aown: HREADYm[i] = HREADY.
  - else: HREADYm[i] = ~req[i]. A requesting non-owner is stalled and must hold its address.
- Response routing: HRDATAm[i] = HRDATA and HRESPm[i] = HRESP only when i==down && dvalid; otherwise 0 (OKAY).
- Data-phase update, on each edge with HREADY=1: down <= aown; dvalid <= req[aown]. When HREADY=0, all registers hold.
- Arbitration, evaluated only at edges with HREADY=1:
  - Switch is allowed when HMASTLOCKm[aown]=0 AND at least one of:
    - (a) HTRANSm[aown]==IDLE;
    - (b) MAX_HOLD>0, HTRANSm[aown]==NONSEQ, HBURSTm[aown]==SINGLE, and holdcnt+1 >= MAX_HOLD.
  - Candidates are masters j != aown with req[j]=1.
  - If a switch is allowed and a candidate exists: aown <= winner per ARB_MODE, holdcnt <= 0.
  - Otherwise aown holds. If the owner presents an accepted NONSEQ/SEQ, holdcnt increments, saturating at MAX_HOLD.
- The owner's transfer present at a switching edge is accepted, since its HREADYm was high. The new owner's held NONSEQ appears on the bus the next cycle.
- SEQ/BUSY beats, bursts and locked sequences are never split.
- Known limitation: back-to-back bursts with no IDLE and no SINGLE transfer are not preempted.
- With no candidate, the grant stays on the current owner; HTRANS then shows the owner's IDLE.
- Two-cycle ERROR response: cycle 1 has HREADY=0, so nothing changes. Cycle 2 routes HRESP=1 to down only.
- Reset mid-transfer: state returns to the reset values immediately. The bus mirrors PARK, and outstanding data phases are dropped.

Test Plan:
- Reset, NMASTER=2, PARK=0, master 0 IDLE and master 1 NONSEQ at 0x100 -> HREADYm[1]=0 for 1 cycle. Next cycle HMASTER=1 and HADDR=0x100. Following cycle HWDATA=HWDATAm[1].
- Master 1 in a 4-beat INCR4 while master 0 requests -> master 0 stalled (HREADYm[0]=0) through all SEQ beats. HMASTER switches to 0 only after master 1 presents IDLE.
- MAX_HOLD=4, master 0 issuing continuous NONSEQ SINGLE, master 1 requesting -> exactly 4 transfers by master 0 accepted, then HMASTER=1.
- NMASTER=4, ARB_MODE=1, all masters requesting singles with owner idling between transfers -> grant order 0,1,2,3,0. With ARB_MODE=0 -> master 0 is served whenever it requests.
- Slave inserts 2 wait states (HREADY=0) while another master requests -> HMASTER and down are unchanged; the stalled master's HADDR is held. Slave ERROR -> HRESPm=1 on the data-phase owner only.
- HRESETn asserted mid-burst owned by master 1 -> HMASTER=PARK and dvalid=0 asynchronously; all HRESPm=0.

Source files
------------

// File: rtl/ahb_arbiter_nm_if.sv
// ahb_arbiter_nm_if: master-side and slave-side AHB-Lite signals around the arbiter
interface ahb_arbiter_nm_if #(
  parameter int NMASTER = 2
);
  localparam int MW = NMASTER > 1 ? $clog2(NMASTER) : 1;
  logic [NMASTER*32-1:0] HADDRm;
  logic [NMASTER*3-1:0]  HBURSTm;
  logic [NMASTER-1:0]    HMASTLOCKm;
  logic [NMASTER*4-1:0]  HPROTm;
  logic [NMASTER*3-1:0]  HSIZEm;
  logic [NMASTER*2-1:0]  HTRANSm;
  logic [NMASTER*32-1:0] HWDATAm;
  logic [NMASTER-1:0]    HWRITEm;
  logic [NMASTER*32-1:0] HRDATAm;
  logic [NMASTER-1:0]    HREADYm;
  logic [NMASTER-1:0]    HRESPm;
  logic [31:0]           HADDR;
  logic [2:0]            HBURST;
  logic                  HMASTLOCK;
  logic [3:0]            HPROT;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic [31:0]           HWDATA;
  logic                  HWRITE;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [MW-1:0]         HMASTER;
  logic [NMASTER-1:0]    HGRANT;
  modport master (
    input  HADDRm, HBURSTm, HMASTLOCKm, HPROTm, HSIZEm, HTRANSm, HWDATAm, HWRITEm,
    input  HRDATA, HREADY, HRESP,
    output HRDATAm, HREADYm, HRESPm,
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE, HMASTER, HGRANT
  );
  modport slave (
    output HADDRm, HBURSTm, HMASTLOCKm, HPROTm, HSIZEm, HTRANSm, HWDATAm, HWRITEm,
    output HRDATA, HREADY, HRESP,
    input  HRDATAm, HREADYm, HRESPm,
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE, HMASTER, HGRANT
  );
endinterface

// File: rtl/ahb_arbiter_nm.sv
// ahb_arbiter_nm: AHB-Lite N-master arbiter with separate address/data owners and bounded hold
module ahb_arbiter_nm #(
  parameter int NMASTER  = 2,
  parameter int ARB_MODE = 1,
  parameter int MAX_HOLD = 4,
  parameter int PARK     = 0
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_arbiter_nm_if.master bus
);
  localparam int MW = NMASTER > 1 ? $clog2(NMASTER) : 1;
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10;
  logic [MW-1:0] aown, down, win;
  logic dvalid, found, sw;
  logic [HW-1:0] holdcnt;
  logic [NMASTER-1:0] req, cand;
  logic [1:0] otrans;
  logic [2:0] oburst;
  function automatic int pick(int k, int a);
    return ARB_MODE != 0 ? (a + k + 1) % NMASTER : k;
  endfunction
  // request decode and candidate set (every requester other than the owner)
  always_comb begin
    req = '0;
    cand = '0;
    for (int i = 0; i < NMASTER; i++) begin
      req[i] = bus.HTRANSm[2*i+1];
      cand[i] = bus.HTRANSm[2*i+1] && i != int'(aown);
    end
  end
  // switch only at a transfer boundary: owner idle, or its hold budget on singles is spent
  always_comb begin
    otrans = bus.HTRANSm[2*aown +: 2];
    oburst = bus.HBURSTm[3*aown +: 3];
    sw = !bus.HMASTLOCKm[aown] && (otrans == IDLE || (MAX_HOLD > 0 && otrans == NONSEQ &&
         oburst == 3'b000 && int'(holdcnt) + 1 >= MAX_HOLD));
  end
  // winner search: lowest index for fixed priority, first after the owner for round-robin
  always_comb begin
    win = aown;
    found = 1'b0;
    for (int k = 0; k < NMASTER; k++)
      if (!found && cand[pick(k, int'(aown))]) begin
        win = MW'(pick(k, int'(aown)));
        found = 1'b1;
      end
  end
  // address-phase signals follow the address owner, write data follows the data owner
  always_comb begin
    bus.HADDR = bus.HADDRm[32*aown +: 32];
    bus.HBURST = bus.HBURSTm[3*aown +: 3];
    bus.HMASTLOCK = bus.HMASTLOCKm[aown];
    bus.HPROT = bus.HPROTm[4*aown +: 4];
    bus.HSIZE = bus.HSIZEm[3*aown +: 3];
    bus.HTRANS = bus.HTRANSm[2*aown +: 2];
    bus.HWRITE = bus.HWRITEm[aown];
    bus.HWDATA = bus.HWDATAm[32*down +: 32];
    bus.HMASTER = aown;
  end
  // per-master ready/response: owners see the slave, requesting non-owners are stalled
  always_comb begin
    bus.HGRANT = '0;
    bus.HGRANT[aown] = 1'b1;
    bus.HREADYm = '0;
    bus.HRESPm = '0;
    bus.HRDATAm = '0;
    for (int i = 0; i < NMASTER; i++) begin
      bus.HREADYm[i] = (dvalid && int'(down) == i) || int'(aown) == i ? bus.HREADY : !req[i];
      bus.HRESPm[i] = dvalid && int'(down) == i && bus.HRESP;
      bus.HRDATAm[32*i +: 32] = dvalid && int'(down) == i ? bus.HRDATA : 32'h0;
    end
  end
  // owner/data-phase/hold state advances only when the slave is ready
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      aown <= MW'(PARK);
      down <= '0;
      dvalid <= 1'b0;
      holdcnt <= '0;
    end else if (bus.HREADY) begin
      down <= aown;
      dvalid <= req[aown];
      aown <= sw && found ? win : aown;
      holdcnt <= sw && found ? '0 : req[aown] && int'(holdcnt) < MAX_HOLD ? holdcnt + 1'b1 : holdcnt;
    end
endmodule

// File: tb/tb_ahb_arbiter_nm.sv
// tb_ahb_arbiter_nm: directed scoreboard bench for ahb_arbiter_nm
module tb_ahb_arbiter_nm;
  localparam logic [1:0] ID = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] INCR4 = 3'b011;
  typedef struct { int m; logic [31:0] a; } acc_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  acc_t sb[$];
  always #5 clk = ~clk;
  ahb_arbiter_nm_if #(.NMASTER(4)) rb ();
  ahb_arbiter_nm_if #(.NMASTER(4)) fx ();
  ahb_arbiter_nm #(.NMASTER(4), .ARB_MODE(1), .MAX_HOLD(4), .PARK(0)) u_rr (
    .HCLK(clk), .HRESETn(rstn), .bus(rb));
  ahb_arbiter_nm #(.NMASTER(4), .ARB_MODE(0), .MAX_HOLD(0), .PARK(2)) u_fx (
    .HCLK(clk), .HRESETn(rstn), .bus(fx));

  function automatic logic [31:0] wd(int m);
    return 32'hD0D0_0000 | 32'(m);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drv(int i, logic [1:0] tr, logic [31:0] a = 32'h0, logic [2:0] b = 3'b000);
    rb.HTRANSm[2*i +: 2] = tr;
    rb.HADDRm[32*i +: 32] = a;
    rb.HBURSTm[3*i +: 3] = b;
  endtask

  task automatic fdrv(int i, logic [1:0] tr, logic [31:0] a = 32'h0);
    fx.HTRANSm[2*i +: 2] = tr;
    fx.HADDRm[32*i +: 32] = a;
  endtask

  task automatic exp_acc(int m, logic [31:0] a);
    sb.push_back('{m, a});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted address phase pops the scoreboard; its data phase checks HWDATA
  initial begin
    logic pend;
    logic [31:0] pend_wd;
    acc_t e;
    pend = 1'b0;
    pend_wd = '0;
    forever begin
      @(negedge clk);
      if (!rstn) pend = 1'b0;
      else if (rb.HREADY) begin
        if (pend) chk("data_phase_hwdata", rb.HWDATA, pend_wd);
        pend = 1'b0;
        if (rb.HTRANS[1]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_transfer: got master %0d addr %h expected none", rb.HMASTER, rb.HADDR);
          end else begin
            e = sb.pop_front();
            chk("sb_master", 32'(rb.HMASTER), 32'(e.m));
            chk("sb_addr", rb.HADDR, e.a);
            pend = 1'b1;
            pend_wd = wd(e.m);
          end
        end
      end
    end
  end

  initial begin
    rb.HADDRm = '0; rb.HBURSTm = '0; rb.HMASTLOCKm = '0; rb.HPROTm = '0;
    rb.HSIZEm = {4{3'b010}}; rb.HTRANSm = '0; rb.HWRITEm = '1;
    fx.HADDRm = '0; fx.HBURSTm = '0; fx.HMASTLOCKm = '0; fx.HPROTm = '0;
    fx.HSIZEm = {4{3'b010}}; fx.HTRANSm = '0; fx.HWRITEm = '1;
    for (int i = 0; i < 4; i++) begin
      rb.HWDATAm[32*i +: 32] = wd(i);
      fx.HWDATAm[32*i +: 32] = wd(i);
    end
    rb.HRDATA = 32'h1234_5678; rb.HREADY = 1'b1; rb.HRESP = 1'b1;
    fx.HRDATA = '0; fx.HREADY = 1'b1; fx.HRESP = 1'b0;
    // reset state
    @(negedge clk);
    chk("rst_hmaster", 32'(rb.HMASTER), 32'd0);
    chk("rst_hgrant", 32'(rb.HGRANT), 32'h1);
    chk("rst_hrespm", 32'(rb.HRESPm), 32'h0);
    chk("rst_hrdatam1", rb.HRDATAm[63:32], 32'h0);
    chk("rst_park_fx", 32'(fx.HMASTER), 32'd2);
    nxt();
    rb.HRESP = 1'b0; rb.HRDATA = '0;
    rstn = 1'b1;
    // m1 requests while m0 owns and idles: one stall cycle, then m1 on the bus
    drv(1, NS, 32'h100);
    @(negedge clk);
    chk("t1_stall_m1", 32'(rb.HREADYm[1]), 32'd0);
    chk("t1_hmaster0", 32'(rb.HMASTER), 32'd0);
    chk("t1_htrans_idle", 32'(rb.HTRANS), 32'(ID));
    nxt();
    exp_acc(1, 32'h100);
    @(negedge clk);
    chk("t1_grant", 32'(rb.HMASTER), 32'd1);
    chk("t1_haddr", rb.HADDR, 32'h100);
    chk("t1_hgrant", 32'(rb.HGRANT), 32'h2);
    nxt();
    drv(1, ID);
    rb.HRDATA = 32'hCAFE_0001;
    @(negedge clk);
    chk("t1_hwdata", rb.HWDATA, wd(1));
    chk("t1_hrdata_m1", rb.HRDATAm[63:32], 32'hCAFE_0001);
    chk("t1_hrdata_m0", rb.HRDATAm[31:0], 32'h0);
    nxt();
    // m1 INCR4 burst is not split while m0 waits
    rb.HRDATA = '0;
    drv(1, NS, 32'h200, INCR4);
    drv(0, NS, 32'h010);
    exp_acc(1, 32'h200);
    @(negedge clk);
    chk("t2_stall_m0", 32'(rb.HREADYm[0]), 32'd0);
    nxt();
    for (int k = 1; k < 4; k++) begin
      drv(1, SQ, 32'h200 + 32'(4 * k), INCR4);
      exp_acc(1, 32'h200 + 32'(4 * k));
      @(negedge clk);
      chk("t2_stall_m0", 32'(rb.HREADYm[0]), 32'd0);
      chk("t2_owner", 32'(rb.HMASTER), 32'd1);
      nxt();
    end
    drv(1, ID);
    @(negedge clk);
    chk("t2_hold_on_idle", 32'(rb.HMASTER), 32'd1);
    chk("t2_stall_m0_idle", 32'(rb.HREADYm[0]), 32'd0);
    nxt();
    // m0 issues singles while m1 waits: exactly MAX_HOLD=4 accepted, then preempted
    drv(1, NS, 32'h300);
    exp_acc(0, 32'h010);
    @(negedge clk);
    chk("t2_switch", 32'(rb.HMASTER), 32'd0);
    chk("t3_stall_m1", 32'(rb.HREADYm[1]), 32'd0);
    nxt();
    for (int k = 1; k < 4; k++) begin
      drv(0, NS, 32'h010 + 32'(4 * k));
      exp_acc(0, 32'h010 + 32'(4 * k));
      @(negedge clk);
      chk("t3_stall_m1", 32'(rb.HREADYm[1]), 32'd0);
      chk("t3_owner0", 32'(rb.HMASTER), 32'd0);
      nxt();
    end
    drv(0, ID);
    exp_acc(1, 32'h300);
    @(negedge clk);
    chk("t3_preempt", 32'(rb.HMASTER), 32'd1);
    chk("t3_m0_dphase_ready", 32'(rb.HREADYm[0]), 32'd1);
    nxt();
    drv(1, ID);
    drv(0, NS, 32'h020);
    @(negedge clk);
    chk("t3_stall_m0", 32'(rb.HREADYm[0]), 32'd0);
    nxt();
    // round-robin: 0 then 1,2,3 then back to 0
    exp_acc(0, 32'h020);
    for (int m = 1; m < 4; m++) drv(m, NS, 32'h400 + 32'(16 * m));
    @(negedge clk);
    chk("t4_owner0", 32'(rb.HMASTER), 32'd0);
    nxt();
    drv(0, ID);
    @(negedge clk);
    chk("t4_idle_shown", 32'(rb.HTRANS), 32'(ID));
    nxt();
    drv(0, NS, 32'h404);
    for (int m = 1; m < 4; m++) begin
      exp_acc(m, 32'h400 + 32'(16 * m));
      @(negedge clk);
      chk("t4_rr_order", 32'(rb.HMASTER), 32'(m));
      nxt();
      drv(m, ID);
      nxt();
    end
    exp_acc(0, 32'h404);
    @(negedge clk);
    chk("t4_rr_wrap", 32'(rb.HMASTER), 32'd0);
    nxt();
    // two wait states with m1 requesting: nothing moves
    drv(0, NS, 32'h408);
    drv(1, NS, 32'h500);
    rb.HREADY = 1'b0;
    rb.HRDATA = 32'h5A5A_0000;
    @(negedge clk);
    chk("t5_wait_owner", 32'(rb.HMASTER), 32'd0);
    chk("t5_wait_ready_m0", 32'(rb.HREADYm[0]), 32'd0);
    chk("t5_wait_stall_m1", 32'(rb.HREADYm[1]), 32'd0);
    chk("t5_wait_hrdata_m1", rb.HRDATAm[63:32], 32'h0);
    nxt();
    @(negedge clk);
    chk("t5_wait2_owner", 32'(rb.HMASTER), 32'd0);
    chk("t5_wait2_haddr", rb.HADDR, 32'h408);
    chk("t5_wait2_down", rb.HRDATAm[31:0], 32'h5A5A_0000);
    nxt();
    rb.HREADY = 1'b1;
    rb.HRDATA = '0;
    exp_acc(0, 32'h408);
    nxt();
    // two-cycle ERROR on m0's data phase
    drv(0, ID);
    rb.HREADY = 1'b0;
    rb.HRESP = 1'b1;
    @(negedge clk);
    chk("t5_err1_m0", 32'(rb.HRESPm[0]), 32'd1);
    chk("t5_err1_others", 32'(rb.HRESPm[3:1]), 32'd0);
    nxt();
    rb.HREADY = 1'b1;
    @(negedge clk);
    chk("t5_err2_m0", 32'(rb.HRESPm[0]), 32'd1);
    chk("t5_err2_others", 32'(rb.HRESPm[3:1]), 32'd0);
    chk("t5_err2_owner", 32'(rb.HMASTER), 32'd0);
    nxt();
    // m1 burst interrupted by asynchronous reset
    rb.HRESP = 1'b0;
    exp_acc(1, 32'h500);
    @(negedge clk);
    chk("t6_owner1", 32'(rb.HMASTER), 32'd1);
    nxt();
    drv(1, NS, 32'h600, INCR4);
    exp_acc(1, 32'h600);
    nxt();
    drv(1, SQ, 32'h604, INCR4);
    exp_acc(1, 32'h604);
    nxt();
    drv(1, SQ, 32'h608, INCR4);
    rb.HRESP = 1'b1;
    rb.HRDATA = 32'hFFFF_0000;
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_park", 32'(rb.HMASTER), 32'd0);
    chk("t6_hgrant", 32'(rb.HGRANT), 32'h1);
    chk("t6_hrespm", 32'(rb.HRESPm), 32'h0);
    chk("t6_hrdata_m1", rb.HRDATAm[63:32], 32'h0);
    nxt();
    drv(1, ID);
    rb.HRESP = 1'b0;
    rb.HRDATA = '0;
    nxt();
    rstn = 1'b1;
    // fixed priority instance parked on master 2, no preemption
    for (int i = 0; i < 4; i++) fdrv(i, NS, 32'h700 + 32'(16 * i));
    @(negedge clk);
    chk("f_park", 32'(fx.HMASTER), 32'd2);
    chk("f_stall_m0", 32'(fx.HREADYm[0]), 32'd0);
    nxt();
    fdrv(2, ID);
    @(negedge clk);
    chk("f_hold_idle", 32'(fx.HMASTER), 32'd2);
    nxt();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("f_prio0_nohold", 32'(fx.HMASTER), 32'd0);
      nxt();
    end
    fdrv(0, ID);
    nxt();
    fdrv(0, NS, 32'h704);
    @(negedge clk);
    chk("f_next1", 32'(fx.HMASTER), 32'd1);
    nxt();
    fdrv(1, ID);
    nxt();
    @(negedge clk);
    chk("f_prio0_again", 32'(fx.HMASTER), 32'd0);
    nxt();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
